// File: rtl/mull_pkg.sv
// Shared encodings and constants for the iterative long-multiply unit.
package mull_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam int OP_SIGNED = 0;
  localparam int OP_ACC    = 1;

  localparam logic [4:0] CNT_LAST = 5'd31;

  // Destination register indices captured with the request
  typedef struct packed {
    logic [3:0] lo;
    logic [3:0] hi;
  } wa_pair_t;

endpackage

// File: rtl/mull_datapath.sv
// Operand magnitudes, radix-2 shift-add product, final sign fix and accumulate.
module mull_datapath
  import mull_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   acc_hi,
  input  logic [WIDTH-1:0]   acc_lo,
  output logic [2*WIDTH-1:0] res
);

  logic [2*WIDTH-1:0] mcand, prod, acc, prod_s;
  logic [WIDTH-1:0]   mplier;
  logic               neg, acc_en;

  // The most negative value maps to itself, which reads correctly as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      acc_en <= 1'b0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, mag(a, op[OP_SIGNED])};
      mplier <= mag(b, op[OP_SIGNED]);
      prod   <= '0;
      acc    <= {acc_hi, acc_lo};
      neg    <= op[OP_SIGNED] & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_en <= op[OP_ACC];
    end else if (step) begin
      prod   <= prod + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  always_comb begin
    prod_s = neg ? (~prod + 1'b1) : prod;
    res    = prod_s + (acc_en ? acc : '0);
  end

endmodule

// File: rtl/mull_unit.sv
// UMULL/SMULL/UMLAL/SMLAL controller: FSM, step count and registered write ports.
module mull_unit
  import mull_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [3:0]       wa_lo_in,
  input  logic [3:0]       wa_hi_in,
  output logic             busy,
  output logic             done,
  output logic             we3,
  output logic [3:0]       wa3,
  output logic [WIDTH-1:0] wd3,
  output logic             we0,
  output logic [3:0]       wa0,
  output logic [WIDTH-1:0] wd0
);

  state_t             state, nxt;
  logic [4:0]         cnt;
  wa_pair_t           wa_q;
  logic               load, step;
  logic [2*WIDTH-1:0] res;

  assign load = (state == IDLE) && start;
  assign step = (state == MUL);

  mull_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .op     (op),
    .a      (a),
    .b      (b),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .res    (res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = MUL;
      MUL:     if (cnt == CNT_LAST) nxt = FIX;
      FIX:     nxt = WB;
      WB:      nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      wa_q <= '0;
    end else if (load) begin
      cnt  <= '0;
      wa_q <= '{lo: wa_lo_in, hi: wa_hi_in};
    end else if (step) begin
      cnt  <= cnt + 1'b1;
    end
  end

  // Write ports load on the FIX edge so they are stable for the whole WB cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      we3  <= 1'b0;
      we0  <= 1'b0;
      wa3  <= '0;
      wa0  <= '0;
      wd3  <= '0;
      wd0  <= '0;
    end else begin
      done <= 1'b0;
      we3  <= 1'b0;
      we0  <= 1'b0;
      if (load) busy <= 1'b1;
      if (state == FIX) begin
        wd3  <= res[WIDTH-1:0];
        wd0  <= res[2*WIDTH-1:WIDTH];
        wa3  <= wa_q.lo;
        wa0  <= wa_q.hi;
        we0  <= 1'b1;
        we3  <= (wa_q.lo != wa_q.hi);  // same register: RdHi wins
        done <= 1'b1;
      end
      if (state == WB) begin
        busy <= 1'b0;
        wa3  <= '0;
        wa0  <= '0;
        wd3  <= '0;
        wd0  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mull_unit.sv
// Randomised and directed checks of mull_unit against a plain-arithmetic model.
module tb_mull_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0, b = '0, acc_hi = '0, acc_lo = '0;
  logic [3:0]  wa_lo_in = '0, wa_hi_in = '0;
  logic        busy, done, we3, we0;
  logic [3:0]  wa3, wa0;
  logic [31:0] wd3, wd0;

  int n_cmp = 0;
  int n_err = 0;

  mull_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .acc_hi(acc_hi), .acc_lo(acc_lo), .wa_lo_in(wa_lo_in), .wa_hi_in(wa_hi_in),
    .busy(busy), .done(done), .we3(we3), .wa3(wa3), .wd3(wd3),
    .we0(we0), .wa0(wa0), .wd0(wd0)
  );

  always #5 clk = ~clk;

  // 64-bit wraparound product of sign- or zero-extended operands, plus accumulator.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, y, ah, al);
    logic [63:0] xe, ye, p;
    xe = o[0] ? {{32{x[31]}}, x} : {32'b0, x};
    ye = o[0] ? {{32{y[31]}}, y} : {32'b0, y};
    p  = xe * ye;
    if (o[1]) p = p + {ah, al};
    return p;
  endfunction

  task automatic exec(input string nm, input logic [1:0] o, input logic [31:0] ia, ib, ah, al,
                      input logic [3:0] wl, wh, input bit mid);
    logic [63:0] exp;
    int lat;
    exp = model(o, ia, ib, ah, al);
    @(negedge clk);
    start = 1'b1; op = o; a = ia; b = ib; acc_hi = ah; acc_lo = al;
    wa_lo_in = wl; wa_hi_in = wh;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    acc_hi = $urandom; acc_lo = $urandom; wa_lo_in = 4'($urandom); wa_hi_in = 4'($urandom);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_rise got %b want 1", nm, busy); end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      start = mid && (k == 4 || k == 9);
      if (start) begin a = $urandom; b = $urandom; op = 2'($urandom); end
      @(posedge clk); #1;
      if (we0 || we3 || done) begin lat = k; break; end
    end
    start = 1'b0;
    n_cmp++;
    if (lat != 33) begin
      n_err++; $display("FAIL %s latency got %0d edges want 33", nm, lat);
    end
    if (lat > 0) begin
      n_cmp++;
      if ({done, we0, we3} !== {2'b11, wl != wh}) begin
        n_err++; $display("FAIL %s strobes done/we0/we3 got %b%b%b want 11%b", nm, done, we0, we3, wl != wh);
      end
      n_cmp++;
      if (wa0 !== wh || (wl != wh && wa3 !== wl)) begin
        n_err++; $display("FAIL %s addr got wa0=%0d wa3=%0d want wa0=%0d wa3=%0d", nm, wa0, wa3, wh, wl);
      end
      n_cmp++;
      if (wd0 !== exp[63:32]) begin
        n_err++; $display("FAIL %s wd0 got %h want %h", nm, wd0, exp[63:32]);
      end
      n_cmp++;
      if (wd3 !== exp[31:0]) begin
        n_err++; $display("FAIL %s wd3 got %h want %h", nm, wd3, exp[31:0]);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done, we0, we3} !== 4'b0000) begin
        n_err++; $display("FAIL %s after_wb busy/done/we0/we3 got %b%b%b%b want 0000", nm, busy, done, we0, we3);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, we3, we0, wa3, wa0, wd3, wd0} !== '0) begin
      n_err++; $display("FAIL reset_state got busy=%b done=%b we3=%b we0=%b wd3=%h wd0=%h want all 0",
                        busy, done, we3, we0, wd3, wd0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    exec("umull_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'd2, 4'd3, 1'b0);
    exec("smull_neg", 2'b01, 32'hFFFF_FFFF, 32'd5, 32'h0, 32'h0, 4'd1, 4'd7, 1'b0);
    exec("smull_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 4'd5, 4'd6, 1'b0);
    exec("umlal_carry", 2'b10, 32'd2, 32'd3, 32'h0, 32'hFFFF_FFFF, 4'd8, 4'd9, 1'b0);
  endtask

  task automatic test_equal_idx();
    exec("smlal_eq", 2'b11, 32'hFFFF_FFF0, 32'd1000, 32'h1234_5678, 32'h9ABC_DEF0, 4'd4, 4'd4, 1'b0);
  endtask

  task automatic test_busy_start();
    exec("busy_start", 2'b01, 32'h0001_2345, 32'hFFFF_FF00, 32'h0, 32'h0, 4'd10, 4'd11, 1'b1);
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'hDEAD_BEEF; b = 32'h1234_5678; wa_lo_in = 4'd1; wa_hi_in = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, we3, we0, wa3, wa0, wd3, wd0} !== '0) begin
      n_err++; $display("FAIL reset_mid outputs got busy=%b we3=%b we0=%b want all 0", busy, we3, we0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy || done || we0 || we3) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++; $display("FAIL reset_mid_no_write got %0d active cycles want 0", seen);
    end
    exec("after_reset", 2'b01, 32'h7FFF_FFFF, 32'h8000_0001, 32'h0, 32'h0, 4'd12, 4'd13, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic [3:0]  wl, wh;
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0:       x = 32'h8000_0000;
        1:       x = 32'hFFFF_FFFF;
        default: x = $urandom;
      endcase
      y  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      wl = 4'($urandom);
      wh = ($urandom_range(0, 5) == 0) ? wl : 4'($urandom);
      exec("random", 2'($urandom), x, y, $urandom, $urandom, wl, wh, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_equal_idx();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
